// File: rtl/ks_xor_reader.sv
// rtl/ks_xor_reader.sv - keystream block reader XORing a plaintext byte stream into ciphertext.
// Optional end-of-message sideband (pt_last/ct_last) enabled by defining KSX_LAST_EN.
module ks_xor_reader #(
    parameter int DATA_SIZE = 8,
    parameter int NO_REG    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_SIZE*NO_REG-1:0] concatin,
    input  logic                      blockready,
    output logic                      blk_req,
    input  logic [DATA_SIZE-1:0]      pt_data,
    input  logic                      pt_valid,
    output logic                      pt_ready,
`ifdef KSX_LAST_EN
    input  logic                      pt_last,
    output logic                      ct_last,
`endif
    output logic [DATA_SIZE-1:0]      ct_data,
    output logic                      ct_valid,
    input  logic                      ct_ready,
    output logic [31:0]               blk_count
);

    localparam int IW = (NO_REG > 1) ? $clog2(NO_REG) : 1;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IW-1:0]         idx;
    logic [DATA_SIZE-1:0]  buffer [NO_REG];
    logic [31:0]           blk_count_q;
    logic                  accept;
    logic                  capture;
    logic                  msg_end;
    logic [DATA_SIZE-1:0]  ks_byte;

`ifdef KSX_LAST_EN
    assign msg_end = pt_last;
`else
    assign msg_end = 1'b0;
`endif

    assign ks_byte   = buffer[idx];
    assign blk_count = blk_count_q;

    always_comb begin
        state_next = state;
        pt_ready   = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            S_REQ: state_next = S_WAIT;
            S_WAIT: begin
                if (blockready) begin
                    capture    = 1'b1;
                    state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                // Accept only when the output register is free or being emptied this cycle.
                pt_ready = !ct_valid || ct_ready;
                accept   = pt_valid && pt_ready;
                if (accept && ((idx == IW'(NO_REG - 1)) || msg_end)) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx         <= '0;
            blk_req     <= 1'b0;
            ct_valid    <= 1'b0;
            ct_data     <= '0;
            blk_count_q <= '0;
`ifdef KSX_LAST_EN
            ct_last     <= 1'b0;
`endif
            for (int i = 0; i < NO_REG; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            // REQ lasts exactly one cycle, so the registered request is a single pulse.
            blk_req <= (state == S_REQ);
            if (capture) begin
                for (int i = 0; i < NO_REG; i++) begin
                    buffer[i] <= concatin[i*DATA_SIZE +: DATA_SIZE];
                end
                idx         <= '0;
                blk_count_q <= blk_count_q + 32'd1;
            end
            if (accept) begin
                ct_data  <= pt_data ^ ks_byte;
                ct_valid <= 1'b1;
                idx      <= idx + IW'(1);
`ifdef KSX_LAST_EN
                ct_last  <= pt_last;
`endif
            end else if (ct_ready) begin
                ct_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ks_xor_reader.sv
// tb/tb_ks_xor_reader.sv - randomized self-checking bench for ks_xor_reader with a keystream queue model.
module tb_ks_xor_reader;

    localparam int DS = 8;
    localparam int NR = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DS*NR-1:0]  concatin = '0;
    logic              blockready = 1'b0;
    logic              blk_req;
    logic [DS-1:0]     pt_data = '0;
    logic              pt_valid = 1'b0;
    logic              pt_ready;
    logic [DS-1:0]     ct_data;
    logic              ct_valid;
    logic              ct_ready = 1'b0;
    logic [31:0]       blk_count;
`ifdef KSX_LAST_EN
    logic              pt_last = 1'b0;
    logic              ct_last;
`endif

    always #5 clk = ~clk;

    ks_xor_reader #(.DATA_SIZE(DS), .NO_REG(NR)) dut (
        .clk(clk), .rst(rst), .concatin(concatin), .blockready(blockready), .blk_req(blk_req),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
`ifdef KSX_LAST_EN
        .pt_last(pt_last), .ct_last(ct_last),
`endif
        .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready), .blk_count(blk_count)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] ks_q[$];
    logic [7:0] exp_q[$];
    logic       exp_last_q[$];
    logic [31:0] exp_blk_count = 0;

    bit serve_en = 0, serve_pattern = 0, stray = 0, pending_req = 0, pt_ff = 0, last_mode = 0;
    int last_pos = 0, pv_pct = 0, cr_pct = 0;
    int cycle = 0, blk_req_pulses = 0, n_acc = 0, n_ct = 0, last_ct_cycle = 0, last_ct_idx = -1;
    bit prev_acc = 0, prev_hold = 0, prev_blk_req = 0;
    logic [7:0] prev_ct_data = 0;

    task automatic step();
        logic [7:0] b, e;
        logic el;
        @(negedge clk);
        cycle++;
        if (prev_acc) begin
            n_checks++;
            if (ct_valid !== 1'b1) begin n_fail++; $display("FAIL latency: ct_valid=%b required 1", ct_valid); end
        end
        if (prev_hold) begin
            n_checks++;
            if (ct_valid !== 1'b1 || ct_data !== prev_ct_data) begin
                n_fail++; $display("FAIL hold: ct_valid=%b ct_data=%h required 1/%h", ct_valid, ct_data, prev_ct_data);
            end
        end
        if (blk_req === 1'b1) begin
            blk_req_pulses++;
            pending_req = 1;
            n_checks++;
            if (prev_blk_req) begin n_fail++; $display("FAIL blk_req_width: high 2 cycles, required 1"); end
        end
        prev_blk_req = (blk_req === 1'b1);
        blockready = 1'b0;
        for (int i = 0; i < NR; i++) concatin[i*DS +: DS] = 8'($urandom);
        if (pending_req && serve_en) begin
            for (int i = 0; i < NR; i++) begin
                b = serve_pattern ? 8'(i) : 8'($urandom);
                concatin[i*DS +: DS] = b;
                ks_q.push_back(b);
            end
            blockready = 1'b1;
            pending_req = 0;
            exp_blk_count++;
        end else if (stray) begin
            concatin = {NR{8'hAA}};
            blockready = 1'b1;
        end
        pt_valid = ($urandom_range(99) < pv_pct);
        pt_data  = pt_ff ? 8'hFF : 8'($urandom);
        ct_ready = ($urandom_range(99) < cr_pct);
`ifdef KSX_LAST_EN
        pt_last  = last_mode && ((NR - ks_q.size()) == last_pos);
`endif
        #1;
        if (ct_valid === 1'b1 && ct_ready) begin
            n_ct++;
            last_ct_cycle = cycle;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL ct_extra: ct_data=%h with no byte expected", ct_data);
            end else begin
                e  = exp_q.pop_front();
                el = exp_last_q.pop_front();
                if (ct_data !== e) begin n_fail++; $display("FAIL ct_data: got %h required %h", ct_data, e); end
`ifdef KSX_LAST_EN
                n_checks++;
                if (ct_last !== el) begin n_fail++; $display("FAIL ct_last: got %b required %b", ct_last, el); end
                if (ct_last === 1'b1) last_ct_idx = n_ct;
`endif
            end
        end
        prev_hold = (ct_valid === 1'b1) && !ct_ready;
        prev_ct_data = ct_data;
        prev_acc = pt_valid && (pt_ready === 1'b1);
        if (pt_ready === 1'b1) begin
            n_checks++;
            if (ks_q.size() == 0) begin n_fail++; $display("FAIL ready_no_ks: pt_ready=1 required 0"); end
        end
        if (prev_acc && ks_q.size() > 0) begin
            n_acc++;
            e = pt_data ^ ks_q.pop_front();
            exp_q.push_back(e);
`ifdef KSX_LAST_EN
            exp_last_q.push_back(pt_last);
            if (pt_last) ks_q.delete();
`else
            exp_last_q.push_back(1'b0);
`endif
        end
    endtask

    task automatic run_ct(input int nbytes, input int budget, input string name);
        int target;
        target = n_ct + nbytes;
        for (int i = 0; i < budget && n_ct < target; i++) step();
        n_checks++;
        if (n_ct < target) begin n_fail++; $display("FAIL %s_timeout: got %0d ct bytes required %0d", name, n_ct - target + nbytes, nbytes); end
    endtask

    task automatic wait_pending(input string name);
        for (int i = 0; i < 400 && !pending_req; i++) step();
        n_checks++;
        if (!pending_req) begin n_fail++; $display("FAIL %s_req_timeout: blk_req=0 required 1", name); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (blk_req !== 1'b0)  begin n_fail++; $display("FAIL rst_blk_req: got %b required 0", blk_req); end
        if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pt_ready: got %b required 0", pt_ready); end
        if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ct_valid: got %b required 0", ct_valid); end
        if (ct_data !== 8'h00) begin n_fail++; $display("FAIL rst_ct_data: got %h required 00", ct_data); end
        if (blk_count !== 32'd0) begin n_fail++; $display("FAIL rst_blk_count: got %0d required 0", blk_count); end
        rst = 1'b1;
        blk_req_pulses = 0;
        step();
        n_checks++;
        if (blk_req_pulses != 1) begin n_fail++; $display("FAIL first_blk_req: pulses %0d required 1", blk_req_pulses); end
    endtask

    task automatic test_single_block();
        int n0, first;
        serve_en = 1; serve_pattern = 1; pt_ff = 1; pv_pct = 100; cr_pct = 100;
        n0 = n_ct; first = -1;
        for (int i = 0; i < 200 && n_ct < n0 + 64; i++) begin
            step();
            if (exp_blk_count == 1) serve_en = 0;
            if (first < 0 && n_ct == n0 + 1) first = last_ct_cycle;
        end
        n_checks++;
        if (n_ct != n0 + 64) begin n_fail++; $display("FAIL single_count: got %0d required 64", n_ct - n0); end
        n_checks++;
        if (last_ct_cycle - first != 63) begin n_fail++; $display("FAIL single_rate: span %0d required 63", last_ct_cycle - first); end
        for (int i = 0; i < 10 && blk_req_pulses < 2; i++) step();
        n_checks += 2;
        if (blk_req_pulses != 2) begin n_fail++; $display("FAIL single_pulses: got %0d required 2", blk_req_pulses); end
        if (blk_count !== 32'd1) begin n_fail++; $display("FAIL single_blk_count: got %0d required 1", blk_count); end
        serve_pattern = 0; pt_ff = 0;
    endtask

    task automatic test_random_stream();
        serve_en = 1; pv_pct = 70; cr_pct = 60;
        run_ct(300, 3000, "random");
        serve_en = 0; pv_pct = 0; cr_pct = 100;
        repeat (4) step();
        n_checks += 2;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_drain: %0d bytes pending required 0", exp_q.size()); end
        if (blk_count !== exp_blk_count) begin n_fail++; $display("FAIL random_blk_count: got %0d required %0d", blk_count, exp_blk_count); end
    endtask

    task automatic test_back_to_back();
        int last_acc, gap, got;
        bit boundary;
        serve_en = 1; pv_pct = 100; cr_pct = 100;
        last_acc = -1; boundary = 0; got = 0;
        for (int i = 0; i < 400 && got < 150; i++) begin
            step();
            if (prev_acc) begin
                got++;
                if (last_acc >= 0) begin
                    gap = boundary ? 3 : 1;
                    n_checks++;
                    if (cycle - last_acc != gap) begin n_fail++; $display("FAIL b2b_gap: got %0d required %0d", cycle - last_acc, gap); end
                end
                boundary = (ks_q.size() == 0);
                last_acc = cycle;
            end
        end
        n_checks++;
        if (got < 150) begin n_fail++; $display("FAIL b2b_timeout: got %0d accepts required 150", got); end
    endtask

    task automatic test_backpressure();
        int acc0;
        logic [7:0] hold;
        serve_en = 1; pv_pct = 100; cr_pct = 100;
        for (int i = 0; i < 300 && !(ct_valid === 1'b1 && pt_ready === 1'b1 && ks_q.size() > 8); i++) step();
        cr_pct = 0;
        step();
        hold = ct_data;
        acc0 = n_acc;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks += 3;
            if (ct_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b required 1", ct_valid); end
            if (ct_data !== hold)  begin n_fail++; $display("FAIL bp_data: got %h required %h", ct_data, hold); end
            if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b required 0", pt_ready); end
        end
        n_checks++;
        if (n_acc != acc0) begin n_fail++; $display("FAIL bp_accepts: got %0d required 0", n_acc - acc0); end
        cr_pct = 100;
        run_ct(20, 200, "bp_resume");
    endtask

    task automatic test_stray_strobe();
        logic [31:0] cnt;
        serve_en = 1; pv_pct = 100; cr_pct = 100;
        for (int i = 0; i < 300 && !(pt_ready === 1'b1 && ks_q.size() > 4 && !pending_req); i++) step();
        cnt = blk_count;
        stray = 1;
        step();
        stray = 0;
        repeat (2) step();
        n_checks++;
        if (blk_count !== cnt) begin n_fail++; $display("FAIL stray_blk_count: got %0d required %0d", blk_count, cnt); end
        run_ct(80, 400, "stray");
    endtask

    task automatic test_mid_block_reset();
        serve_en = 1; pv_pct = 100; cr_pct = 100;
        for (int i = 0; i < 300 && !(prev_acc && ks_q.size() == NR - 21); i++) step();
        n_checks++;
        if (ks_q.size() != NR - 21) begin n_fail++; $display("FAIL mrst_setup: ks left %0d required %0d", ks_q.size(), NR - 21); end
        @(negedge clk);
        pt_valid = 1'b0; blockready = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks += 5;
        if (blk_req !== 1'b0)  begin n_fail++; $display("FAIL mrst_blk_req: got %b required 0", blk_req); end
        if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_pt_ready: got %b required 0", pt_ready); end
        if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_ct_valid: got %b required 0", ct_valid); end
        if (ct_data !== 8'h00) begin n_fail++; $display("FAIL mrst_ct_data: got %h required 00", ct_data); end
        if (blk_count !== 32'd0) begin n_fail++; $display("FAIL mrst_blk_count: got %0d required 0", blk_count); end
        ks_q.delete(); exp_q.delete(); exp_last_q.delete();
        exp_blk_count = 0; pending_req = 0;
        prev_acc = 0; prev_hold = 0; prev_blk_req = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        blk_req_pulses = 0;
        step();
        n_checks++;
        if (blk_req_pulses != 1) begin n_fail++; $display("FAIL mrst_blk_req_pulse: got %0d required 1", blk_req_pulses); end
        run_ct(100, 400, "mrst");
        n_checks++;
        if (blk_count !== exp_blk_count) begin n_fail++; $display("FAIL mrst_count: got %0d required %0d", blk_count, exp_blk_count); end
    endtask

    task automatic test_counter_wrap();
        serve_en = 0; pv_pct = 100; cr_pct = 100;
        wait_pending("wrap");
        dut.blk_count_q = 32'hFFFF_FFFF;
        exp_blk_count = 32'hFFFF_FFFF;
        serve_en = 1;
        step();
        pv_pct = 0;
        repeat (2) step();
        n_checks++;
        if (blk_count !== 32'd0 || exp_blk_count !== 32'd0) begin
            n_fail++; $display("FAIL wrap: got %0d required 0", blk_count);
        end
        pv_pct = 100;
        run_ct(30, 200, "wrap");
    endtask

`ifdef KSX_LAST_EN
    task automatic test_last();
        int n0, p0;
        bit seen;
        serve_en = 0; pv_pct = 100; cr_pct = 100;
        wait_pending("last");
        n0 = n_ct; last_ct_idx = -1; seen = 0;
        last_mode = 1; last_pos = 9; serve_en = 1;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (prev_acc && pt_last) seen = 1;
        end
        last_mode = 0; pv_pct = 0;
        p0 = blk_req_pulses;
        serve_en = 0;
        for (int i = 0; i < 8 && blk_req_pulses == p0; i++) step();
        n_checks += 3;
        if (!seen) begin n_fail++; $display("FAIL last_accept: pt_last byte not accepted"); end
        if (blk_req_pulses == p0) begin n_fail++; $display("FAIL last_req: no blk_req after pt_last"); end
        if (last_ct_idx - n0 != 10) begin n_fail++; $display("FAIL last_pos: ct_last on byte %0d required 10", last_ct_idx - n0); end
        serve_en = 1; pv_pct = 100;
        run_ct(20, 200, "last_next");
    endtask
`endif

    initial begin
        test_reset();
        test_single_block();
        test_random_stream();
        test_back_to_back();
        test_backpressure();
        test_stray_strobe();
        test_mid_block_reset();
        test_counter_wrap();
`ifdef KSX_LAST_EN
        test_last();
`endif
        serve_en = 0; pv_pct = 0; cr_pct = 100;
        repeat (4) step();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_drain: %0d bytes pending required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ks_xor_reader.md
KS_XOR_READER -- requirements
Module: ks_xor_reader

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, meaning byte width of keystream, plaintext and ciphertext lanes.
REQ-002 The block SHALL have parameter NO_REG, default 64, meaning keystream bytes per ChaCha20 block.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  clock, rising edge; rst  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port concatin  input  DATA_SIZE x NO_REG  serialised keystream block, byte 0 used first.
REQ-005 The block SHALL have port blockready  input  1  keystream block valid on concatin.
REQ-006 The block SHALL have port blk_req  output  1  one-cycle pulse requesting the next keystream block.
REQ-007 The block SHALL have ports pt_data  input  DATA_SIZE, pt_valid  input  1, and pt_ready  output  1 forming the plaintext byte stream.
REQ-008 The block SHALL have ports ct_data  output  DATA_SIZE, ct_valid  output  1, and ct_ready  input  1 forming the ciphertext byte stream.
REQ-009 The block SHALL have port blk_count  output  32  number of keystream blocks captured since reset.

Function
REQ-010 The block SHALL implement a three-state FSM:
- REQ: assert blk_req for exactly one cycle, then go to WAIT.
- WAIT: on blockready=1, capture all NO_REG bytes into the internal buffer, clear byte index idx, increment blk_count, and go to STREAM.
- STREAM: byte transfer.
REQ-011 The block SHALL ignore blockready in REQ and STREAM; the buffer SHALL change only on capture in WAIT.
REQ-012 pt_ready SHALL be 1 only in STREAM and only when (ct_valid=0 or ct_ready=1).
REQ-013 On pt_valid=1 and pt_ready=1, the block SHALL register ct_data = pt_data XOR buffer[idx], set ct_valid=1, and increment idx; latency is exactly one cycle.
REQ-014 ct_valid SHALL clear on ct_ready=1 when no new byte is accepted that same cycle; ct_data SHALL hold stable while ct_valid=1 and ct_ready=0.
REQ-015 Simultaneous ct_ready=1 and a new accept SHALL overwrite ct_data with the new byte, keeping ct_valid=1, so there are no bubbles at full rate.
REQ-016 When the byte at idx=NO_REG-1 is accepted, the FSM SHALL go to REQ on the next cycle and pt_ready SHALL be 0 until the next capture.
REQ-017 A pending output byte SHALL drain normally during REQ and WAIT.
REQ-018 blk_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-019 The minimum gap between the last byte of a block and the first byte of the next block SHALL be 3 cycles (REQ, WAIT with blockready, STREAM).

Reset
REQ-020 On rst=0, asynchronously, the block SHALL set: state=REQ, idx=0, blk_req=0, pt_ready=0, ct_valid=0, ct_data=0, blk_count=0, buffer cleared.
REQ-021 Reset asserted mid-block SHALL discard the buffer and the pending ct byte.
REQ-022 The first blk_req SHALL pulse on the first clk edge after rst deasserts.

Configuration
REQ-023 With macro KSX_LAST_EN defined, the block SHALL add port pt_last  input  1 (end of message, qualified with pt_valid) and port ct_last  output  1 (registered alongside ct_data).
REQ-024 With KSX_LAST_EN defined, accepting a byte with pt_last=1 SHALL send the FSM to REQ regardless of idx, discarding the remaining keystream bytes.
REQ-025 Without KSX_LAST_EN, the pt_last and ct_last ports SHALL be absent and keystream SHALL be consumed contiguously across messages.

Verification
REQ-026 Scenario, single block: reset release, then concatin bytes k[i]=i and blockready pulsed in WAIT, then 64 plaintext bytes 0xFF with ct_ready=1 -> ct bytes 0xFF^i, i=0..63, one per cycle, blk_count=1, blk_req pulsed twice in total.
REQ-027 Scenario, backpressure: ct_ready=0 for 5 cycles with pt_valid=1 -> ct_valid=1, ct_data stable, pt_ready=0, idx unchanged; after ct_ready=1 the stream resumes with no lost or duplicated byte.
REQ-028 Scenario, stray strobe: blockready=1 with concatin all 0xAA pulsed during STREAM -> output unaffected, blk_count unchanged.
REQ-029 Scenario, mid-block reset: rst=0 after byte 20 -> all outputs at reset values immediately; after release, blk_req pulses and the next block starts at byte 0.
REQ-030 Scenario, counter wrap: blk_count forced to 32'hFFFFFFFF, then one capture -> blk_count=0.
REQ-031 Scenario, KSX_LAST_EN: pt_last=1 on byte 9 -> ct_last=1 on the 10th ct byte, then blk_req pulses, and the next plaintext byte is XORed with byte 0 of the new block.
